// File: rtl/code_sender.sv
// Serial unlock-code transmitter: shifts a latched code MSB-first onto req_out,
// waits for the lock's grant and retries after a forced-zero gap on timeout.
module code_sender #(
    parameter int unsigned          CODE_LEN     = 7,
    parameter logic [CODE_LEN-1:0]  DEFAULT_CODE = 7'b1101011,
    parameter int unsigned          ACK_TIMEOUT  = 4,
    parameter int unsigned          GAP_CYCLES   = 2,
    parameter int unsigned          MAX_RETRY    = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                use_default,
    input  logic [CODE_LEN-1:0] code_in,
    input  logic                gnt_in,
    output logic                req_out,
    output logic                busy,
    output logic                done,
    output logic                fail
);

    localparam int unsigned BIT_W    = $clog2(CODE_LEN + 1);
    localparam int unsigned WAIT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int unsigned RETRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        GAP
    } state_e;

    state_e               state_q, state_d;
    logic [CODE_LEN-1:0]  shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [RETRY_W-1:0]   retry_cnt_q, retry_cnt_d;
    logic                 req_out_q, req_out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 fail_q, fail_d;

    // The code rotates rather than shifts, so after CODE_LEN bits it is back
    // in its original position and a retry can resend it unchanged.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        retry_cnt_d = retry_cnt_q;
        req_out_d   = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        fail_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d     = use_default ? DEFAULT_CODE : code_in;
                    retry_cnt_d = '0;
                    bit_cnt_d   = '0;
                    busy_d      = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (bit_cnt_q == BIT_W'(CODE_LEN)) begin
                    wait_cnt_d = '0;
                    state_d    = WAIT_ACK;
                end else begin
                    req_out_d = shift_q[CODE_LEN-1];
                    shift_d   = {shift_q[CODE_LEN-2:0], shift_q[CODE_LEN-1]};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            WAIT_ACK: begin
                if (gnt_in) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (wait_cnt_q == WAIT_W'(ACK_TIMEOUT - 1)) begin
                    wait_cnt_d = '0;
                    if (retry_cnt_q < RETRY_W'(MAX_RETRY)) begin
                        retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                        state_d     = GAP;
                    end else begin
                        fail_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            GAP: begin
                // Leaving GAP emits the MSB directly so the line is low for exactly GAP_CYCLES.
                if (wait_cnt_q == WAIT_W'(GAP_CYCLES - 1)) begin
                    req_out_d  = shift_q[CODE_LEN-1];
                    shift_d    = {shift_q[CODE_LEN-2:0], shift_q[CODE_LEN-1]};
                    bit_cnt_d  = BIT_W'(1);
                    wait_cnt_d = '0;
                    state_d    = SEND;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            retry_cnt_q <= '0;
            req_out_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            req_out_q   <= req_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
        end
    end

    // NOTE: the code register has no reset; it is always loaded on start before SEND reads it.
    always_ff @(posedge clock) begin
        shift_q <= shift_d;
    end

    assign req_out = req_out_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign fail    = fail_q;

endmodule

// File: tb/tb_code_sender.sv
// Directed bench for code_sender: default instance plus a MAX_RETRY=0 instance,
// sampling outputs 1 time unit after each rising edge.
module tb_code_sender;

    localparam logic [6:0] DEF_CODE = 7'b1101011;
    localparam logic [6:0] USR_CODE = 7'b1010011;

    logic       clock;
    logic       reset;
    logic       start;
    logic       start_nr;
    logic       use_default;
    logic [6:0] code_in;
    logic       gnt_in;
    logic       req_out, busy, done, fail;
    logic       nr_req_out, nr_busy, nr_done, nr_fail;

    int n_checks = 0;
    int n_fail   = 0;
    int ones, dones, fails, fail_edge;

    code_sender dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .use_default(use_default),
        .code_in    (code_in),
        .gnt_in     (gnt_in),
        .req_out    (req_out),
        .busy       (busy),
        .done       (done),
        .fail       (fail)
    );

    code_sender #(.MAX_RETRY(0)) dut_nr (
        .clock      (clock),
        .reset      (reset),
        .start      (start_nr),
        .use_default(use_default),
        .code_in    (code_in),
        .gnt_in     (gnt_in),
        .req_out    (nr_req_out),
        .busy       (nr_busy),
        .done       (nr_done),
        .fail       (nr_fail)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Seven edges of one default-instance code burst, MSB first.
    task automatic expect_burst(input string tag, input logic [6:0] code);
        for (int k = 0; k < 7; k++) begin
            step();
            check($sformatf("%s_bit%0d", tag, k), 32'(req_out), 32'(code[6-k]));
            check($sformatf("%s_busy%0d", tag, k), 32'(busy), 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        start_nr    = 1'b0;
        use_default = 1'b1;
        code_in     = '0;
        gnt_in      = 1'b0;
        repeat (3) step();
        check("rst_req", 32'(req_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_nr_busy", 32'(nr_busy), 32'd0);
        check("rst_nr_req", 32'(nr_req_out), 32'd0);
        reset = 1'b1;
        step();

        // Default code, immediate grant: done at E9.
        start = 1'b1;
        step();
        start = 1'b0;
        expect_burst("t1", DEF_CODE);
        step();
        check("t1_e8_req", 32'(req_out), 32'd0);
        check("t1_e8_busy", 32'(busy), 32'd1);
        check("t1_e8_done", 32'(done), 32'd0);
        gnt_in = 1'b1;
        step();
        check("t1_e9_done", 32'(done), 32'd1);
        check("t1_e9_busy", 32'(busy), 32'd0);
        check("t1_e9_fail", 32'(fail), 32'd0);
        gnt_in = 1'b0;
        step();
        check("t1_e10_done", 32'(done), 32'd0);

        // User code, no retries, no grant: fail at E12.
        use_default = 1'b0;
        code_in     = USR_CODE;
        start_nr    = 1'b1;
        step();
        start_nr = 1'b0;
        code_in  = 7'b0101100;
        for (int k = 0; k < 7; k++) begin
            step();
            check($sformatf("t2_bit%0d", k), 32'(nr_req_out), 32'(USR_CODE[6-k]));
        end
        for (int e = 8; e < 12; e++) begin
            step();
            check($sformatf("t2_e%0d_fail", e), 32'(nr_fail), 32'd0);
        end
        step();
        check("t2_e12_fail", 32'(nr_fail), 32'd1);
        check("t2_e12_busy", 32'(nr_busy), 32'd0);
        check("t2_e12_done", 32'(nr_done), 32'd0);
        step();
        check("t2_e13_fail", 32'(nr_fail), 32'd0);
        use_default = 1'b1;
        step();

        // Grant only during the second attempt: gap E12..E13, done at E22.
        start = 1'b1;
        step();
        start = 1'b0;
        expect_burst("t3a", DEF_CODE);
        for (int e = 8; e < 12; e++) begin
            step();
            check($sformatf("t3_e%0d_done", e), 32'(done), 32'd0);
        end
        step();
        check("t3_e12_req", 32'(req_out), 32'd0);
        check("t3_e12_busy", 32'(busy), 32'd1);
        check("t3_e12_fail", 32'(fail), 32'd0);
        step();
        check("t3_e13_req", 32'(req_out), 32'd0);
        expect_burst("t3b", DEF_CODE);
        step();
        check("t3_e21_req", 32'(req_out), 32'd0);
        gnt_in = 1'b1;
        step();
        check("t3_e22_done", 32'(done), 32'd1);
        check("t3_e22_busy", 32'(busy), 32'd0);
        gnt_in = 1'b0;
        step();

        // Never granted: three bursts, single fail at E38.
        ones = 0; dones = 0; fails = 0; fail_edge = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            step();
            if (req_out) ones++;
            if (done) dones++;
            if (fail) begin
                fails++;
                fail_edge = e;
            end
        end
        check("t4_ones", 32'(ones), 32'd15);
        check("t4_dones", 32'(dones), 32'd0);
        check("t4_fails", 32'(fails), 32'd1);
        check("t4_fail_edge", 32'(fail_edge), 32'd38);
        check("t4_busy_end", 32'(busy), 32'd0);

        // Reset mid-SEND, then a clean restart from the MSB.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t5_pre_bit%0d", k), 32'(req_out), 32'(DEF_CODE[6-k]));
        end
        reset = 1'b0;
        step();
        check("t5_e4_req", 32'(req_out), 32'd0);
        check("t5_e4_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        step();
        check("t5_e5_req", 32'(req_out), 32'd0);
        check("t5_e5_busy", 32'(busy), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        expect_burst("t5", DEF_CODE);
        step();
        gnt_in = 1'b1;
        step();
        check("t5_done", 32'(done), 32'd1);
        gnt_in = 1'b0;
        step();

        // Starts at E3 and on the done edge are ignored; E10 start is accepted.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            start = (k == 2);
            step();
            check($sformatf("t6_bit%0d", k), 32'(req_out), 32'(DEF_CODE[6-k]));
        end
        start = 1'b0;
        step();
        check("t6_e8_req", 32'(req_out), 32'd0);
        gnt_in = 1'b1;
        start  = 1'b1;
        step();
        check("t6_e9_done", 32'(done), 32'd1);
        check("t6_e9_busy", 32'(busy), 32'd0);
        gnt_in = 1'b0;
        step();
        check("t6_e10_done", 32'(done), 32'd0);
        check("t6_e10_busy", 32'(busy), 32'd1);
        check("t6_e10_req", 32'(req_out), 32'd0);
        start = 1'b0;
        expect_burst("t6b", DEF_CODE);
        step();
        check("t6_e18_req", 32'(req_out), 32'd0);
        gnt_in = 1'b1;
        step();
        check("t6_e19_done", 32'(done), 32'd1);
        gnt_in = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
